// File: rtl/alu_operand_stage_pkg.sv
// Shared ALU operation codes, RV32I opcode constants and the funct3-to-ALU mapping
// used by the operand stage decode.
package alu_operand_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // alt selects SUB over ADD and SRA over SRL; other funct3 values ignore it
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_operand_stage_imm_gen.sv
// Sign-extended I/S/U immediates extracted from an RV32I instruction word.
module imm_gen (
    input  logic [31:7] i_instr,
    output logic [31:0] o_imm_i,
    output logic [31:0] o_imm_s,
    output logic [31:0] o_imm_u
);

    assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign o_imm_u = {i_instr[31:12], 12'b0};

endmodule

// File: rtl/alu_operand_stage.sv
// RV32I decode/issue stage: derives ALU op and operands, then holds them in a
// single-entry valid/ready pipeline buffer that feeds the ALU directly.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_alu_op,
    output logic [DATA_WIDTH-1:0] out_operand_a,
    output logic [DATA_WIDTH-1:0] out_operand_b,
    output logic [DATA_WIDTH-1:0] out_rs2_data,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [4:0]            out_rd,
    output logic                  out_rd_we,
    output logic                  out_illegal
);

    logic [6:0]            w_opcode;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic [4:0]            w_rd;
    logic [31:0]           w_imm_i;
    logic [31:0]           w_imm_s;
    logic [31:0]           w_imm_u;
    alu_op_e               w_op;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic                  w_writes;
    logic                  w_illegal;
    logic                  w_rd_we;
    logic                  w_accept;

    logic                  r_valid;
    alu_op_e               r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_rs2;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [4:0]            r_rd;
    logic                  r_rd_we;
    logic                  r_illegal;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_rd     = in_instr[11:7];

    imm_gen u_imm_gen (
        .i_instr (in_instr[31:7]),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_u (w_imm_u)
    );

    always_comb begin
        w_op      = ALU_ADD;
        w_a       = '0;
        w_b       = '0;
        w_writes  = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_a      = in_rs1_data;
                w_b      = in_rs2_data;
                w_writes = 1'b1;
                if (w_f7 == FUNCT7_BASE) begin
                    w_op = alu_from_f3(w_f3, 1'b0);
                end else if (w_f7 == FUNCT7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    w_op = alu_from_f3(w_f3, 1'b1);
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                w_a      = in_rs1_data;
                w_b      = w_imm_i;
                w_writes = 1'b1;
                w_op     = alu_from_f3(w_f3, 1'b0);
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_b  = {27'b0, in_instr[24:20]};
                    w_op = alu_from_f3(w_f3, in_instr[30] && (w_f3 == 3'b101));
                    if (w_f7 != FUNCT7_BASE && w_f7 != FUNCT7_ALT) begin
                        w_illegal = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                w_b      = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_AUIPC: begin
                w_a      = in_pc;
                w_b      = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // operands form the link value pc+4
                w_a       = in_pc;
                w_b       = 32'd4;
                w_writes  = 1'b1;
                w_illegal = (w_opcode == OPC_JALR) && (w_f3 != 3'b000);
            end
            OPC_LOAD: begin
                w_a      = in_rs1_data;
                w_b      = w_imm_i;
                w_writes = 1'b1;
            end
            OPC_STORE: begin
                w_a = in_rs1_data;
                w_b = w_imm_s;
            end
            OPC_BRANCH: begin
                w_a = in_rs1_data;
                w_b = in_rs2_data;
                case (w_f3)
                    3'b000, 3'b001: w_op = ALU_SUB;
                    3'b100, 3'b101: w_op = ALU_SLT;
                    3'b110, 3'b111: w_op = ALU_SLTU;
                    default:        w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_op     = ALU_ADD;
            w_a      = '0;
            w_b      = '0;
            w_writes = 1'b0;
        end
    end

    assign w_rd_we  = w_writes && (w_rd != 5'd0);
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_op      <= ALU_ADD;
            r_a       <= '0;
            r_b       <= '0;
            r_rs2     <= '0;
            r_pc      <= '0;
            r_rd      <= '0;
            r_rd_we   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_op      <= w_op;
            r_a       <= w_a;
            r_b       <= w_b;
            r_rs2     <= in_rs2_data;
            r_pc      <= in_pc;
            r_rd      <= w_rd;
            r_rd_we   <= w_rd_we;
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_alu_op    = r_op;
    assign out_operand_a = r_a;
    assign out_operand_b = r_b;
    assign out_rs2_data  = r_rs2;
    assign out_pc        = r_pc;
    assign out_rd        = r_rd;
    assign out_rd_we     = r_rd_we;
    assign out_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed decode table, handshake
// sequences and randomized traffic against an instruction-level reference model.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [31:0] out_operand_a;
    logic [31:0] out_operand_b;
    logic [31:0] out_rs2_data;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    alu_operand_stage #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (out_alu_op),
        .out_operand_a (out_operand_a),
        .out_operand_b (out_operand_b),
        .out_rs2_data  (out_rs2_data),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_rd_we     (out_rd_we),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    int   n_chk = 0;
    int   n_err = 0;
    exp_t m;
    exp_t reset_exp;

    task automatic chk(input string nm, input logic [139:0] act, input logic [139:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t dut_now();
        exp_t d;
        d.valid = out_valid;
        d.op    = out_alu_op;
        d.a     = out_operand_a;
        d.b     = out_operand_b;
        d.rs2   = out_rs2_data;
        d.pc    = out_pc;
        d.rd    = out_rd;
        d.we    = out_rd_we;
        d.ill   = out_illegal;
        return d;
    endfunction

    // Instruction-level reference: what the ALU should be told for one instruction
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [3:0]  base [8];
        logic [3:0]  br   [8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ii, is, iu;
        logic        legal, writes, shift;
        base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        br   = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
        f3 = ins[14:12];
        f7 = ins[31:25];
        ii = 32'($signed(ins[31:20]));
        is = 32'($signed({ins[31:25], ins[11:7]}));
        iu = {ins[31:12], 12'h000};
        e.valid = 1'b1; e.pc = pc; e.rs2 = r2; e.rd = ins[11:7];
        e.op = ALU_ADD; e.a = 0; e.b = 0; e.ill = 1'b0;
        legal = 1'b1; writes = 1'b0;
        case (ins[6:0])
            7'h33: begin
                legal  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.op   = (f7 == 7'h00) ? base[f3] : ((f3 == 3'd0) ? 4'(ALU_SUB) : 4'(ALU_SRA));
                e.a = r1; e.b = r2; writes = 1'b1;
            end
            7'h13: begin
                shift = (f3 == 3'd1) || (f3 == 3'd5);
                legal = !shift || f7 == 7'h00 || f7 == 7'h20;
                e.op  = (f3 == 3'd5 && ins[30]) ? 4'(ALU_SRA) : base[f3];
                e.a = r1; e.b = shift ? 32'(ins[24:20]) : ii; writes = 1'b1;
            end
            7'h37: begin e.a = 0;  e.b = iu; writes = 1'b1; end
            7'h17: begin e.a = pc; e.b = iu; writes = 1'b1; end
            7'h6F: begin e.a = pc; e.b = 4;  writes = 1'b1; end
            7'h67: begin e.a = pc; e.b = 4;  writes = 1'b1; legal = (f3 == 3'd0); end
            7'h03: begin e.a = r1; e.b = ii; writes = 1'b1; end
            7'h23: begin e.a = r1; e.b = is; end
            7'h63: begin e.a = r1; e.b = r2; e.op = br[f3]; legal = (f3 != 3'd2 && f3 != 3'd3); end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.op = ALU_ADD; e.a = 0; e.b = 0; writes = 1'b0; e.ill = 1'b1;
        end
        e.we = writes && (e.rd != 5'd0);
        return e;
    endfunction

    // One clock: check in_ready, advance the model on current inputs, compare after the edge
    task automatic tick(input string nm);
        exp_t nxt;
        logic full;
        @(negedge clk);
        chk({nm, ".in_ready"}, 140'(in_ready), 140'(!m.valid || out_ready));
        nxt  = m;
        full = rst;
        if (rst) nxt = reset_exp;
        else if (flush) nxt.valid = 1'b0;
        else if (in_valid && (!m.valid || out_ready)) nxt = ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
        else if (out_ready) nxt.valid = 1'b0;
        @(posedge clk);
        #1;
        m = nxt;
        if (m.valid || full) chk({nm, ".outs"}, dut_now(), m);
        else chk({nm, ".out_valid"}, 140'(out_valid), 140'(1'b0));
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h6F;
            5: w[6:0] = 7'h67;
            6: w[6:0] = 7'h03;
            7: w[6:0] = 7'h23;
            8: w[6:0] = 7'h63;
            default: ;
        endcase
        if (k <= 1 && $urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        exp_t held;
        tbl[0]  = '{32'h402081B3, 32'h0,   32'd10,        32'd3,    ALU_SUB,  32'd10,        32'd3,         5'd3,  1'b1, 1'b0};
        tbl[1]  = '{32'h40435293, 32'h4,   32'h80000000,  32'h7,    ALU_SRA,  32'h80000000,  32'd4,         5'd5,  1'b1, 1'b0};
        tbl[2]  = '{32'h12345097, 32'h100, 32'h11,        32'h22,   ALU_ADD,  32'h100,       32'h12345000,  5'd1,  1'b1, 1'b0};
        tbl[3]  = '{32'h00000013, 32'h8,   32'h55,        32'h66,   ALU_ADD,  32'h55,        32'h0,         5'd0,  1'b0, 1'b0};
        tbl[4]  = '{32'hFFFFFFFF, 32'hC,   32'h1,         32'h2,    ALU_ADD,  32'h0,         32'h0,         5'd31, 1'b0, 1'b1};
        tbl[5]  = '{32'h00002063, 32'h10,  32'h3,         32'h4,    ALU_ADD,  32'h0,         32'h0,         5'd0,  1'b0, 1'b1};
        tbl[6]  = '{32'hABCDE3B7, 32'h14,  32'h99,        32'h5,    ALU_ADD,  32'h0,         32'hABCDE000,  5'd7,  1'b1, 1'b0};
        tbl[7]  = '{32'h008000EF, 32'h200, 32'h1,         32'h2,    ALU_ADD,  32'h200,       32'd4,         5'd1,  1'b1, 1'b0};
        tbl[8]  = '{32'h000010E7, 32'h204, 32'h1,         32'h2,    ALU_ADD,  32'h0,         32'h0,         5'd1,  1'b0, 1'b1};
        tbl[9]  = '{32'hFE20AE23, 32'h208, 32'h1000,      32'hBEEF, ALU_ADD,  32'h1000,      32'hFFFFFFFC,  5'd28, 1'b0, 1'b0};
        tbl[10] = '{32'h0020E063, 32'h20C, 32'd5,         32'd9,    ALU_SLTU, 32'd5,         32'd9,         5'd0,  1'b0, 1'b0};
        tbl[11] = '{32'hFFF12203, 32'h210, 32'h2000,      32'h3,    ALU_ADD,  32'h2000,      32'hFFFFFFFF,  5'd4,  1'b1, 1'b0};
        tbl[12] = '{32'h02208133, 32'h214, 32'h7,         32'h8,    ALU_ADD,  32'h0,         32'h0,         5'd2,  1'b0, 1'b1};
        tbl[13] = '{32'h4230D293, 32'h218, 32'h7,         32'h8,    ALU_ADD,  32'h0,         32'h0,         5'd5,  1'b0, 1'b1};
        tbl[14] = '{32'hFFB0A313, 32'h21C, 32'h30,        32'h8,    ALU_SLT,  32'h30,        32'hFFFFFFFB,  5'd6,  1'b1, 1'b0};
        tbl[15] = '{32'h002091B3, 32'h220, 32'h1,         32'h5,    ALU_SLL,  32'h1,         32'h5,         5'd3,  1'b1, 1'b0};
        tbl[16] = '{32'h00000012, 32'h224, 32'h1,         32'h2,    ALU_ADD,  32'h0,         32'h0,         5'd0,  1'b0, 1'b1};

        reset_exp = '0;
        reset_exp.op = ALU_ADD;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        m = reset_exp;
        chk("reset.outs", dut_now(), reset_exp);
        chk("reset.in_ready", 140'(in_ready), 140'(1'b1));
        rst = 1'b0;

        // directed decode table
        for (int i = 0; i < NVEC; i++) begin
            exp_t want;
            in_valid = 1'b1; out_ready = 1'b1;
            drive(tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2);
            tick($sformatf("vec%0d", i));
            want = '{1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rs2, tbl[i].pc, tbl[i].rd, tbl[i].we, tbl[i].ill};
            chk($sformatf("vec%0d.table", i), dut_now(), want);
        end

        // backpressure: stalled entry holds, then releases and accepts in the same cycle
        drive(tbl[0].instr, tbl[0].pc, tbl[0].rs1, tbl[0].rs2);
        tick("bp.load");
        held = dut_now();
        out_ready = 1'b0;
        drive(tbl[2].instr, tbl[2].pc, tbl[2].rs1, tbl[2].rs2);
        for (int i = 0; i < 3; i++) begin
            tick($sformatf("bp.stall%0d", i));
            chk($sformatf("bp.stable%0d", i), dut_now(), held);
            chk($sformatf("bp.in_ready%0d", i), 140'(in_ready), 140'(1'b0));
        end
        out_ready = 1'b1;
        tick("bp.release");
        chk("bp.release.a", 140'(out_operand_a), 140'(32'h100));

        // flush during stall with in_valid, then flush while ready
        out_ready = 1'b0;
        drive(tbl[6].instr, tbl[6].pc, tbl[6].rs1, tbl[6].rs2);
        flush = 1'b1;
        tick("flush.stall");
        flush = 1'b0; in_valid = 1'b0;
        tick("flush.after");
        chk("flush.empty", 140'(out_valid), 140'(1'b0));
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        tick("flush.ready");
        flush = 1'b0; in_valid = 1'b0;
        tick("flush.ready.after");

        // reset while stalled drops the entry
        in_valid = 1'b1;
        drive(tbl[11].instr, tbl[11].pc, tbl[11].rs1, tbl[11].rs2);
        tick("rst.load");
        out_ready = 1'b0;
        rst = 1'b1;
        tick("rst.stall");
        rst = 1'b0;

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 79) == 0);
            drive(rand_instr(), $urandom, $urandom, $urandom);
            tick($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
